// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit (rev 1.0): single-outstanding load/store sequencer between the execute stage
// and a word-wide memory port; formats store lanes, checks alignment, extends load data.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  load_q, load_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;

  logic        accept;
  logic        misalign;
  logic [15:0] shifted;
  logic [31:0] ld_val;

  always_comb begin
    accept = (state_q == IDLE) && start && (MemWrite || MemRead);

    // A simultaneous MemWrite/MemRead is a store, so MemWrite alone selects the size rule.
    if (MemWrite)
      misalign = ((Store == 2'b01) && Addr[0]) || (Store[1] && (Addr[1:0] != 2'b00));
    else
      misalign = ((Load[1:0] == 2'b01) && Addr[0]) || (Load[1] && (Addr[1:0] != 2'b00));

    shifted = 16'(mem_rdata >> {off_q, 3'b000});
    case (load_q[1:0])
      2'b00:   ld_val = {{24{shifted[7] & ~load_q[2]}}, shifted[7:0]};
      2'b01:   ld_val = {{16{shifted[15] & ~load_q[2]}}, shifted[15:0]};
      default: ld_val = mem_rdata;
    endcase

    state_d     = state_q;
    is_store_d  = is_store_q;
    load_d      = load_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_store_d = MemWrite;
          load_d     = Load;
          off_d      = Addr[1:0];
          if (misalign) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = MemWrite;
            mem_addr_d = {Addr[31:2], 2'b00};
            if (MemWrite) begin
              case (Store)
                2'b00: begin
                  mem_wstrb_d = 4'b0001 << Addr[1:0];
                  mem_wdata_d = {4{WriteData[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_d = Addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_d = {2{WriteData[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'b1111;
                  mem_wdata_d = WriteData;
                end
              endcase
            end else begin
              mem_wstrb_d = 4'b0000;
              mem_wdata_d = 32'h0;
            end
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          done_d    = 1'b1;
          if (!is_store_q) rdata_d = ld_val;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      load_q      <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      load_q      <= load_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign ReadData   = rdata_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign stall      = accept || (state_q == REQ);
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: randomized scoreboard bench with a byte-lane reference model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  Store = 2'b00;
  logic [2:0]  Load = 3'b000;
  logic [31:0] Addr = 32'h0, WriteData = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ReadData;
  logic        stall, done, misaligned;

  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .MemRead(MemRead),
    .Store(Store), .Load(Load), .Addr(Addr), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ReadData(ReadData), .stall(stall), .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } sb_t;

  mem_exp_t    mq[$];
  sb_t         sq[$];
  logic [31:0] model_rd = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          force_lat = -1;
  bit          abandon = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: access size and natural alignment decide everything.
  task automatic do_op(input bit st, input bit both, input logic [1:0] s, input logic [2:0] l,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input bit track, output int n_stall);
    int size, off;
    bit mis, fin;
    mem_exp_t e;
    sb_t sb;
    if (st) size = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    else    size = (l[1:0] == 2'b00) ? 1 : (l[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    mis = (off % size) != 0;
    if (!mis) begin
      e.addr = {a[31:2], 2'b00};
      e.we = st;
      e.wstrb = 4'b0000;
      e.wdata = 32'h0;
      e.rdata = rd;
      if (st) begin
        for (int i = 0; i < 4; i++) begin
          e.wstrb[i] = (i >= off) && (i < off + size);
          e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
      end else if (track) begin
        logic [31:0] v;
        v = rd >> (8 * off);
        if (size == 1) v = l[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (size == 2) v = l[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        model_rd = v;
      end
      mq.push_back(e);
    end
    if (track) begin
      sb.rd = model_rd;
      sb.mis = mis;
      sq.push_back(sb);
    end
    @(negedge clk);
    start = 1'b1; MemWrite = st; MemRead = !st || both;
    Store = s; Load = l; Addr = a; WriteData = wd;
    #1 chk("stall_on_accept", {31'h0, stall}, 32'h1);
    n_stall = 1;
    fin = 1'b0;
    if (!track) return;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done) begin
        chk("stall_in_done", {31'h0, stall}, 32'h0);
        fin = 1'b1;
        start = 1'b0;
        break;
      end
      if (stall) n_stall++;
      // Starts while busy must be ignored.
      start = 1'($urandom_range(0, 1)); MemWrite = 1'b1; MemRead = 1'($urandom);
      Addr = $urandom; WriteData = $urandom; Store = 2'($urandom); Load = 3'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  // Memory responder: checks the request and holds it until a randomly delayed ack.
  initial begin
    mem_exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req actual=req required=none");
          e.addr = mem_addr; e.we = mem_we; e.wstrb = mem_wstrb; e.wdata = mem_wdata; e.rdata = 0;
        end else e = mq.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        for (int i = 0; i < lat; i++) begin
          mem_ack = 1'b0; mem_rdata = $urandom;
          @(negedge clk);
          if (!abandon) begin
            chk("mem_req_held", {31'h0, mem_req}, 32'h1);
            chk("mem_addr_held", mem_addr, e.addr);
            chk("mem_wstrb_held", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
          end
        end
        mem_ack = 1'b1; mem_rdata = e.rdata;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    sb_t sb;
    if (done) begin
      chk("done_one_cycle", {31'h0, prev_done}, 32'h0);
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=done required=none");
      end else begin
        sb = sq.pop_front();
        chk("misaligned", {31'h0, misaligned}, {31'h0, sb.mis});
        chk("ReadData", ReadData, sb.rd);
      end
    end else if (prev_done) begin
      chk("misaligned_clear", {31'h0, misaligned}, 32'h0);
    end
    prev_done = done;
  end

  initial begin
    int ns;
    bit st, both;
    logic [1:0] s;
    logic [2:0] l;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_ReadData", ReadData, 32'h0);
    chk("rst_flags", {29'h0, stall, done, misaligned}, 32'h0);
    reset = 1'b0;

    force_lat = 1;
    do_op(1, 0, 2'b10, 3'b000, 32'h100, 32'hDEADBEEF, 32'h0, 1, ns);
    chk("sw_stall_cycles", ns, 3);
    force_lat = -1;
    do_op(1, 0, 2'b00, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, ns);
    do_op(0, 0, 2'b00, 3'b000, 32'h201, 32'h0, 32'h00008000, 1, ns);
    do_op(0, 0, 2'b00, 3'b100, 32'h201, 32'h0, 32'h00008000, 1, ns);
    do_op(0, 0, 2'b00, 3'b001, 32'h202, 32'h0, 32'h8001FFFF, 1, ns);
    do_op(0, 0, 2'b00, 3'b101, 32'h202, 32'h0, 32'h8001FFFF, 1, ns);
    do_op(0, 0, 2'b00, 3'b010, 32'h302, 32'h0, 32'h12345678, 1, ns);
    chk("misaligned_stall_cycles", ns, 1);
    do_op(1, 1, 2'b01, 3'b010, 32'h402, 32'hCAFE1234, 32'h0, 1, ns);
    do_op(0, 0, 2'b00, 3'b111, 32'h404, 32'h0, 32'hA5A55A5A, 1, ns);

    // start with neither request is ignored
    @(negedge clk);
    start = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    #1 chk("ignored_start_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("ignored_start_done", {31'h0, done}, 32'h0);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom); both = st && 1'($urandom);
      s = 2'($urandom); l = 3'($urandom);
      a = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3) & (st ? (s == 0 ? 3 : s == 1 ? 2 : 0) : (l[1:0] == 0 ? 3 : l[1:0] == 1 ? 2 : 0)));
      do_op(st, both, s, l, a, $urandom, $urandom, 1, ns);
    end

    // Reset while a request is outstanding abandons it.
    force_lat = 4;
    do_op(0, 0, 2'b00, 3'b010, 32'h500, 32'h0, 32'h11223344, 0, ns);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("req_before_reset", {31'h0, mem_req}, 32'h1);
    abandon = 1'b1;
    reset = 1'b1;
    #1;
    chk("reset_drops_req", {31'h0, mem_req}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_ReadData", ReadData, 32'h0);
    model_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 chk("no_done_after_reset", {30'h0, done, mem_req}, 32'h0);
    end
    abandon = 1'b0;
    force_lat = -1;
    do_op(0, 0, 2'b00, 3'b000, 32'h600, 32'h0, 32'h0000007F, 1, ns);
    do_op(0, 0, 2'b00, 3'b001, 32'h601, 32'h0, 32'hFFFFFFFF, 1, ns);

    repeat (4) @(negedge clk);
    chk("sb_queue_empty", sq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  memory op valid from the execute stage.
REQ-004 SHALL have ports: MemWrite  in  1  store request from the main decoder.
REQ-005 SHALL have ports: MemRead  in  1  load request (ResultSrc==01).
REQ-006 SHALL have ports: Store  in  2  00 sb, 01 sh, 10 sw.
REQ-007 SHALL have ports: Load  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-008 SHALL have ports: Addr  in  32  byte address (ALUResult).
REQ-009 SHALL have ports: WriteData  in  32  store data (rs2).
REQ-010 SHALL have ports: mem_req  out  1 ; mem_we  out  1 ; mem_addr  out  32 (word-aligned, bits[1:0]=00) ; mem_wdata  out  32 ; mem_wstrb  out  4.
REQ-011 SHALL have ports: mem_ack  in  1 ; mem_rdata  in  32.
REQ-012 SHALL have ports: ReadData  out  32 ; stall  out  1 ; done  out  1 ; misaligned  out  1.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE.
REQ-014 IDLE: start=1 with MemWrite or MemRead SHALL latch Store, Load, Addr, WriteData, op type; next state REQ, or DONE if misaligned.
REQ-015 MemWrite and MemRead both high SHALL be treated as a store; start with neither high SHALL be ignored.
REQ-016 Misaligned: sh/lh/lhu with Addr[0]=1, sw/lw with Addr[1:0]!=00; SHALL issue no mem_req.
REQ-017 REQ: mem_req=1; mem_addr, mem_we, mem_wdata, mem_wstrb SHALL be held stable until mem_ack is sampled high.
REQ-018 On the edge mem_ack=1 in REQ: the load result SHALL be captured into ReadData; next state DONE.
REQ-019 mem_ack outside REQ SHALL be ignored.
REQ-020 DONE: done=1 for exactly one cycle; misaligned=1 in this cycle only if REQ-016 applied; next state IDLE.
REQ-021 A misaligned load SHALL leave ReadData unchanged.
REQ-022 stall SHALL be 1 when (IDLE and start accepted) or state==REQ; 0 in DONE and otherwise.
REQ-023 start while not IDLE SHALL be ignored.
REQ-024 Store lanes, k=Addr[1:0]: sb wstrb=1<<k, wdata=byte replicated x4.
REQ-025 Store lanes: sh wstrb=0011 (Addr[1]=0) or 1100, wdata=halfword replicated x2.
REQ-026 Store lanes: sw wstrb=1111, wdata=WriteData; Store=11 SHALL behave as sw.
REQ-027 Load extract: lb/lbu SHALL select byte Addr[1:0], sign-/zero-extended.
REQ-028 Load extract: lh/lhu SHALL select halfword Addr[1], sign-/zero-extended.
REQ-029 Load extract: lw SHALL take the full word; codes 011/110/111 SHALL behave as lw.
REQ-030 For loads, mem_we=0 and mem_wstrb=0000.
REQ-031 ReadData SHALL hold its value until the next completed load.
REQ-032 There is no timeout; mem_req remains asserted until mem_ack.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE.
REQ-034 reset=1 SHALL force mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, ReadData=0, stall=0, done=0, misaligned=0.
REQ-035 Reset during REQ SHALL abandon the access; a later mem_ack SHALL have no effect.

Verification
REQ-036 sw Addr=0x100, WriteData=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall held 3 cycles; done one pulse.
REQ-037 sb Addr=0x103, WriteData=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
REQ-038 lb Addr=0x201, mem_rdata=0x00008000 -> ReadData=0xFFFFFF80; lbu same -> ReadData=0x00000080.
REQ-039 lh Addr=0x202, mem_rdata=0x8001FFFF -> ReadData=0xFFFF8001; lhu -> ReadData=0x00008001.
REQ-040 lw Addr=0x302 -> no mem_req; done=1 and misaligned=1 one cycle after start; ReadData unchanged.
REQ-041 reset asserted while in REQ, then mem_ack -> mem_req drops in the same cycle as reset; no done pulse; state IDLE.
